uart_tx_arbiter: RTL

//  Round-robin arbiter that shares the TX FIFO write port of uart_protocol between NUM_REQ

---
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between NUM_REQ packet sources.
// Optional macro UART_ARB_BURST_LIMIT_EN also releases a grant after MAX_BURST beats.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr,
  output logic [DATA_SIZE-1:0]         fifo_w_data,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t           state_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  grant_id_r;
  logic [CNT_W-1:0] beat_cnt_r;

  logic [ID_W-1:0]      pick_s;
  logic [ID_W-1:0]      idx_s;
  logic                 any_s;
  logic                 hit_s;
  logic                 lock_s;
  logic                 go_s;
  logic                 owner_valid_s;
  logic                 owner_last_s;
  logic [DATA_SIZE-1:0] owner_data_s;
  logic [CNT_W-1:0]     cnt_inc_s;
  logic                 release_s;
  logic [ID_W-1:0]      rr_next_s;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_s = '0;
    any_s  = 1'b0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s  = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      hit_s  = req_valid[idx_s] & ~any_s;
      pick_s = hit_s ? idx_s : pick_s;
      any_s  = any_s | hit_s;
    end
  end

  assign lock_s        = (state_r == ST_LOCK);
  assign owner_valid_s = req_valid[grant_id_r];
  assign owner_last_s  = req_last[grant_id_r];
  assign owner_data_s  = req_data[grant_id_r*DATA_SIZE +: DATA_SIZE];
  assign go_s          = lock_s & s_tick & ~fifo_full;
  assign cnt_inc_s     = beat_cnt_r + CNT_W'(1);
  assign rr_next_s     = (grant_id_r == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_r + ID_W'(1);

`ifdef UART_ARB_BURST_LIMIT_EN
  assign release_s = fifo_wr & (owner_last_s | (cnt_inc_s == CNT_W'(MAX_BURST)));
`else
  assign release_s = fifo_wr & owner_last_s;
`endif

  // Only the owner sees ready, and only on an unblocked tick.
  always_comb begin
    req_ready = '0;
    if (go_s) begin
      req_ready[grant_id_r] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign fifo_wr     = go_s & owner_valid_s;
  assign fifo_w_data = lock_s ? owner_data_s : '0;
  assign grant_id    = grant_id_r;
  assign busy        = lock_s;

  // Arbitration FSM: grant in IDLE, hold ownership in LOCK until release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      grant_id_r <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            grant_id_r <= pick_s;
            beat_cnt_r <= '0;
            state_r    <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (release_s) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= rr_next_s;
            beat_cnt_r <= '0;
          end else if (fifo_wr && !(&beat_cnt_r)) begin
            beat_cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
